memory_stage: RTL and testbench
===============================

Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute, feeding writeback.
- Takes one executed instruction per accepted handshake; passes ALU results through; performs loads/stores over the data-bus request/response handshake.
- Stalls upstream while a memory access is outstanding and emits exactly one registered writeback packet per instruction.

Parameters:
- ADDR_W, 64, width of the address and of pc.
- DATA_W, 64, data width; fixed at 64, with 8 byte strobes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  execute presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_pc  in  64  instruction pc.
- in_dst  in  5  destination register.
- in_wen  in  1  instruction writes rd.
- in_result  in  64  ALU result; this is the effective address for load/store.
- in_store_data  in  64  rs2 value for stores.
- in_load  in  1  load instruction.
- in_store  in  1  store instruction.
- in_size  in  2  access size: 0=B, 1=H, 2=W, 3=D.
- in_unsigned  in  1  zero-extend the load (LBU/LHU/LWU).
- dreq_valid  out  1  data-bus request valid.
- dreq_write  out  1  1=store, 0=load.
- dreq_addr  out  64  access address (unaligned byte address).
- dreq_size  out  2  copy of in_size.
- dreq_strobe  out  8  store byte enables; 0 for loads.
- dreq_wdata  out  64  store data, lane-shifted.
- dresp_ok  in  1  bus completes the request this cycle.
- dresp_data  in  64  raw 64-bit load data (aligned doubleword).
- out_valid  out  1  writeback packet valid, one-cycle pulse.
- out_pc  out  64  pc of the packet.
- out_dst  out  5  destination register.
- out_wen  out  1  register write enable.
- out_data  out  64  writeback value.
- out_misalign  out  1  access was misaligned; no bus access was made, and out_wen=0.

Behaviour:
- Async active-high reset: state=IDLE. All outputs 0 except in_ready=1. This holds even mid-access: dreq_valid drops immediately, and a later dresp_ok is ignored.
- States: IDLE, BUSY.
- in_ready = (state==IDLE). Accept = in_valid & in_ready.
- IDLE, accept, neither load nor store:
  - Next cycle: out_valid=1, out_data=in_result, out_wen=in_wen, out_pc/out_dst copied.
  - Latency 1; back-to-back accepts give one packet per cycle.
- IDLE, accept, load or store:
  - Alignment check: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
  - Misaligned: no bus request. Next cycle out_valid=1, out_misalign=1, out_wen=0, out_data=0. Stay IDLE.
  - Aligned: capture all fields into internal registers; next cycle state=BUSY.
- BUSY:
  - dreq_valid=1; all dreq_* fields driven from the registers and held stable until dresp_ok.
  - Store: strobe = size mask (B=0x01, H=0x03, W=0x0F, D=0xFF) shifted left by addr[2:0]. wdata = store_data shifted left by 8*addr[2:0].
  - Load: strobe=0; wdata=0.
  - On dresp_ok: next cycle state=IDLE, out_valid=1.
    - Load: out_data = (dresp_data >> 8*addr[2:0]) truncated to size, then sign-extended (in_unsigned=0) or zero-extended (in_unsigned=1). out_wen = captured in_wen.
    - Store: out_data=0, out_wen=0.
  - dresp_ok in the same cycle dreq_valid first rises is legal (zero-wait bus).
- dresp_ok outside BUSY is ignored.
- out_valid is deasserted in every cycle not listed above; out_* data fields hold their last value.
- No downstream backpressure; writeback always consumes.
- Minimum memory-op occupancy: accept cycle + 1 BUSY cycle. The next accept happens in the cycle after dresp_ok, because state returns to IDLE there.
- in_load and in_store both set: treated as a load.

Test Plan:
- Reset, then three back-to-back ALU ops with results 0x1, 0x2, 0x3 → out_valid high for 3 consecutive cycles starting 1 cycle after the first accept; out_data=1,2,3; in_ready stays 1.
- LB at addr 0x1003, dresp_data=0x0000_0000_8000_0000 with 0 wait states → dreq_addr=0x1003, strobe=0; out_data=0xFFFF_FFFF_FFFF_FF80. The same access with in_unsigned=1 gives 0x80.
- SW at addr 0x2004, store_data=0xDEADBEEF, dresp_ok after 3 wait cycles → strobe=0xF0, wdata=0xDEADBEEF_00000000; in_ready=0 for 4 cycles; out_valid with out_wen=0.
- LH at addr 0x3001 → no dreq_valid; out_valid=1, out_misalign=1, out_wen=0 one cycle after accept.
- Assert reset while BUSY on an LD, then pulse dresp_ok after reset is released → dreq_valid falls asynchronously; no out_valid; in_ready=1.
- LD at 0x4000 followed by ADDI with in_valid held → ADDI is accepted the cycle after dresp_ok; packets emerge in program order: LD, then ADDI.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: passes ALU results through, runs loads/stores over the data-bus
// handshake and emits one registered writeback packet per instruction.
module memory_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [4:0]        in_dst,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_load,
  input  logic              in_store,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  output logic              dreq_valid,
  output logic              dreq_write,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [DATA_W-1:0] dreq_wdata,
  input  logic              dresp_ok,
  input  logic [DATA_W-1:0] dresp_data,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [4:0]        out_dst,
  output logic              out_wen,
  output logic [DATA_W-1:0] out_data,
  output logic              out_misalign
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, addr_q, addr_d, opc_q, opc_d;
  logic [4:0] dst_q, dst_d, odst_q, odst_d;
  logic wen_q, wen_d, write_q, write_d, uns_q, uns_d;
  logic [1:0] size_q, size_d;
  logic [DATA_W-1:0] sdata_q, sdata_d, odata_q, odata_d;
  logic ovalid_q, ovalid_d, owen_q, owen_d, omis_q, omis_d;
  logic accept, mem, misalign;
  logic [2:0] off;
  logic [7:0] mask;
  logic [DATA_W-1:0] sh, ld;
  assign in_ready = state_q == IDLE;
  assign accept = in_valid & in_ready;
  assign mem = in_load | in_store;
  assign misalign = in_size == 2'd1 ? in_result[0] :
                    in_size == 2'd2 ? |in_result[1:0] :
                    in_size == 2'd3 ? |in_result[2:0] : 1'b0;
  assign off = addr_q[2:0];
  assign mask = size_q == 2'd0 ? 8'h01 : size_q == 2'd1 ? 8'h03 : size_q == 2'd2 ? 8'h0f : 8'hff;
  assign dreq_valid = state_q == BUSY;
  assign dreq_write = write_q;
  assign dreq_addr = addr_q;
  assign dreq_size = size_q;
  assign dreq_strobe = write_q ? mask << off : 8'h00;
  assign dreq_wdata = write_q ? sdata_q << {off, 3'b000} : '0;
  // Bus returns the aligned doubleword; bring the addressed bytes down to lane 0 first.
  assign sh = dresp_data >> {off, 3'b000};
  assign ld = size_q == 2'd0 ? {{56{~uns_q & sh[7]}}, sh[7:0]} :
              size_q == 2'd1 ? {{48{~uns_q & sh[15]}}, sh[15:0]} :
              size_q == 2'd2 ? {{32{~uns_q & sh[31]}}, sh[31:0]} : sh;
  assign out_valid = ovalid_q;
  assign out_pc = opc_q;
  assign out_dst = odst_q;
  assign out_wen = owen_q;
  assign out_data = odata_q;
  assign out_misalign = omis_q;
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    addr_d = addr_q;
    dst_d = dst_q;
    wen_d = wen_q;
    write_d = write_q;
    uns_d = uns_q;
    size_d = size_q;
    sdata_d = sdata_q;
    ovalid_d = 1'b0;
    opc_d = opc_q;
    odst_d = odst_q;
    owen_d = owen_q;
    odata_d = odata_q;
    omis_d = omis_q;
    if (accept && (!mem || misalign)) begin
      ovalid_d = 1'b1;
      opc_d = in_pc;
      odst_d = in_dst;
      owen_d = mem ? 1'b0 : in_wen;
      odata_d = mem ? '0 : in_result;
      omis_d = mem;
    end else if (accept) begin
      state_d = BUSY;
      pc_d = in_pc;
      addr_d = in_result[ADDR_W-1:0];
      dst_d = in_dst;
      wen_d = in_wen;
      write_d = in_store & ~in_load;
      uns_d = in_unsigned;
      size_d = in_size;
      sdata_d = in_store_data;
    end else if (state_q == BUSY && dresp_ok) begin
      state_d = IDLE;
      ovalid_d = 1'b1;
      opc_d = pc_q;
      odst_d = dst_q;
      owen_d = write_q ? 1'b0 : wen_q;
      odata_d = write_q ? '0 : ld;
      omis_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q <= '0;
      addr_q <= '0;
      dst_q <= '0;
      wen_q <= 1'b0;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      size_q <= '0;
      sdata_q <= '0;
      ovalid_q <= 1'b0;
      opc_q <= '0;
      odst_q <= '0;
      owen_q <= 1'b0;
      odata_q <= '0;
      omis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      dst_q <= dst_d;
      wen_q <= wen_d;
      write_q <= write_d;
      uns_q <= uns_d;
      size_q <= size_d;
      sdata_q <= sdata_d;
      ovalid_q <= ovalid_d;
      opc_q <= opc_d;
      odst_q <= odst_d;
      owen_q <= owen_d;
      odata_q <= odata_d;
      omis_q <= omis_d;
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scenarios plus randomized traffic against a byte-level reference model.
module tb_memory_stage;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_wen = 0, in_load = 0, in_store = 0, in_unsigned = 0, dresp_ok = 0;
  logic [63:0] in_pc = 0, in_result = 0, in_store_data = 0, dresp_data = 0;
  logic [4:0] in_dst = 0;
  logic [1:0] in_size = 0;
  logic in_ready, dreq_valid, dreq_write, out_valid, out_wen, out_misalign;
  logic [63:0] dreq_addr, dreq_wdata, out_pc, out_data;
  logic [1:0] dreq_size;
  logic [7:0] dreq_strobe;
  logic [4:0] out_dst;
  int vec = 0, err = 0;

  memory_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_dst(in_dst), .in_wen(in_wen), .in_result(in_result), .in_store_data(in_store_data),
    .in_load(in_load), .in_store(in_store), .in_size(in_size), .in_unsigned(in_unsigned),
    .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
    .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_ok(dresp_ok), .dresp_data(dresp_data), .out_valid(out_valid), .out_pc(out_pc),
    .out_dst(out_dst), .out_wen(out_wen), .out_data(out_data), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pick the n addressed bytes out of the doubleword, then extend to 64 bits.
  function automatic logic [63:0] model_load(logic [63:0] raw, logic [63:0] a, logic [1:0] sz, logic u);
    int n = 1 << sz;
    int o = int'(a[2:0]);
    logic [63:0] v = 0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = raw[8*(o+k) +: 8];
    if (!u && n < 8 && v[8*n-1]) for (int k = 8*n; k < 64; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] model_strobe(logic [63:0] a, logic [1:0] sz);
    int n = 1 << sz;
    int o = int'(a[2:0]);
    logic [7:0] s = 0;
    for (int k = 0; k < 8; k++) if (k >= o && k < o + n) s[k] = 1'b1;
    return s;
  endfunction

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    vec++; if (dreq_valid !== 1'b0) begin err++; $display("FAIL reset_dreq_valid got %b exp 0", dreq_valid); end
    vec++; if ({out_data, out_pc, dreq_addr, dreq_wdata} !== 256'h0) begin err++; $display("FAIL reset_data got %h %h %h %h exp 0", out_data, out_pc, dreq_addr, dreq_wdata); end
    vec++; if ({dreq_strobe, dreq_write, out_wen, out_misalign, out_dst} !== 16'h0) begin err++; $display("FAIL reset_flags got %h %b %b %b %h exp 0", dreq_strobe, dreq_write, out_wen, out_misalign, out_dst); end
    reset = 0;
    tick();
    vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin err++; $display("FAIL post_reset got ready %b valid %b exp 1 0", in_ready, out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1; in_load = 0; in_store = 0; in_wen = 1; in_dst = 5;
    for (int i = 1; i <= 3; i++) begin
      in_result = 64'(i); in_pc = 64'h100 + 64'(4 * i);
      vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL b2b_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      vec++; if (out_valid !== 1'b1 || out_data !== 64'(i) || out_pc !== 64'h100 + 64'(4 * i) || out_wen !== 1'b1 || out_dst !== 5'd5)
        begin err++; $display("FAIL b2b_pkt[%0d] got v%b d%h pc%h w%b exp v1 d%h", i, out_valid, out_data, out_pc, out_wen, 64'(i)); end
    end
    in_valid = 0;
    tick();
    vec++; if (out_valid !== 1'b0 || out_data !== 64'h3) begin err++; $display("FAIL b2b_idle got v%b d%h exp v0 d3", out_valid, out_data); end
  endtask

  task automatic test_load_byte();
    for (int u = 0; u < 2; u++) begin
      in_valid = 1; in_load = 1; in_store = 0; in_size = 0; in_unsigned = u[0];
      in_result = 64'h1003; in_pc = 64'h200; in_dst = 7; in_wen = 1;
      tick();
      in_valid = 0; in_load = 0;
      vec++; if (dreq_valid !== 1'b1 || dreq_addr !== 64'h1003 || dreq_strobe !== 8'h00 || dreq_write !== 1'b0 || dreq_wdata !== 64'h0 || dreq_size !== 2'd0)
        begin err++; $display("FAIL lb_req[%0d] got v%b a%h s%h w%b exp v1 a1003 s00 w0", u, dreq_valid, dreq_addr, dreq_strobe, dreq_write); end
      dresp_ok = 1; dresp_data = 64'h0000_0000_8000_0000;
      tick();
      dresp_ok = 0;
      vec++; if (out_valid !== 1'b1 || out_data !== (u ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80) || out_wen !== 1'b1 || out_dst !== 5'd7)
        begin err++; $display("FAIL lb_data[%0d] got v%b d%h w%b exp v1 d%h", u, out_valid, out_data, out_wen, u ? 64'h80 : 64'hFFFF_FFFF_FFFF_FF80); end
    end
    in_unsigned = 0;
  endtask

  task automatic test_store_word();
    in_valid = 1; in_store = 1; in_load = 0; in_size = 2; in_result = 64'h2004;
    in_store_data = 64'hDEADBEEF; in_pc = 64'h300; in_wen = 1; in_dst = 9;
    tick();
    in_valid = 0; in_store = 0;
    for (int w = 0; w < 4; w++) begin
      vec++; if (in_ready !== 1'b0 || dreq_valid !== 1'b1 || dreq_write !== 1'b1 || dreq_strobe !== 8'hF0 || dreq_wdata !== 64'hDEADBEEF_00000000 || out_valid !== 1'b0)
        begin err++; $display("FAIL sw_busy[%0d] got r%b v%b s%h wd%h o%b exp r0 v1 sF0 wdDEADBEEF00000000 o0", w, in_ready, dreq_valid, dreq_strobe, dreq_wdata, out_valid); end
      if (w == 3) dresp_ok = 1;
      tick();
    end
    dresp_ok = 0;
    vec++; if (out_valid !== 1'b1 || out_wen !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1 || dreq_valid !== 1'b0 || out_pc !== 64'h300)
      begin err++; $display("FAIL sw_done got v%b w%b d%h r%b dv%b exp v1 w0 d0 r1 dv0", out_valid, out_wen, out_data, in_ready, dreq_valid); end
  endtask

  task automatic test_misalign();
    in_valid = 1; in_load = 1; in_size = 1; in_result = 64'h3001; in_pc = 64'h310; in_wen = 1; in_dst = 2;
    tick();
    in_valid = 0; in_load = 0;
    vec++; if (dreq_valid !== 1'b0 || out_valid !== 1'b1 || out_misalign !== 1'b1 || out_wen !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1 || out_pc !== 64'h310)
      begin err++; $display("FAIL misalign got dv%b v%b m%b w%b d%h r%b exp dv0 v1 m1 w0 d0 r1", dreq_valid, out_valid, out_misalign, out_wen, out_data, in_ready); end
    tick();
    vec++; if (out_valid !== 1'b0 || dreq_valid !== 1'b0) begin err++; $display("FAIL misalign_after got v%b dv%b exp 0 0", out_valid, dreq_valid); end
  endtask

  task automatic test_reset_busy();
    in_valid = 1; in_load = 1; in_size = 3; in_result = 64'h5008; in_pc = 64'h320;
    tick();
    in_valid = 0; in_load = 0;
    vec++; if (dreq_valid !== 1'b1) begin err++; $display("FAIL rb_busy got %b exp 1", dreq_valid); end
    #2 reset = 1;
    #1;
    vec++; if (dreq_valid !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin err++; $display("FAIL rb_async got dv%b r%b v%b exp 0 1 0", dreq_valid, in_ready, out_valid); end
    tick();
    reset = 0;
    dresp_ok = 1; dresp_data = 64'h1234;
    tick();
    dresp_ok = 0;
    vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || dreq_valid !== 1'b0) begin err++; $display("FAIL rb_after got v%b r%b dv%b exp 0 1 0", out_valid, in_ready, dreq_valid); end
  endtask

  task automatic test_ld_then_addi();
    in_valid = 1; in_load = 1; in_size = 3; in_unsigned = 0; in_result = 64'h4000; in_pc = 64'h400; in_dst = 3; in_wen = 1;
    tick();
    in_load = 0; in_result = 64'h77; in_pc = 64'h404; in_dst = 4;
    vec++; if (in_ready !== 1'b0 || dreq_valid !== 1'b1 || dreq_addr !== 64'h4000) begin err++; $display("FAIL ldaddi_busy got r%b dv%b a%h exp 0 1 4000", in_ready, dreq_valid, dreq_addr); end
    tick();
    vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin err++; $display("FAIL ldaddi_wait got r%b v%b exp 0 0", in_ready, out_valid); end
    dresp_ok = 1; dresp_data = 64'h1122334455667788;
    tick();
    dresp_ok = 0;
    vec++; if (out_valid !== 1'b1 || out_pc !== 64'h400 || out_data !== 64'h1122334455667788 || out_dst !== 5'd3 || in_ready !== 1'b1)
      begin err++; $display("FAIL ldaddi_ld got v%b pc%h d%h r%b exp v1 pc400 d1122334455667788 r1", out_valid, out_pc, out_data, in_ready); end
    tick();
    in_valid = 0;
    vec++; if (out_valid !== 1'b1 || out_pc !== 64'h404 || out_data !== 64'h77 || out_dst !== 5'd4)
      begin err++; $display("FAIL ldaddi_addi got v%b pc%h d%h exp v1 pc404 d77", out_valid, out_pc, out_data); end
    tick();
    vec++; if (out_valid !== 1'b0) begin err++; $display("FAIL ldaddi_end got %b exp 0", out_valid); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      logic [63:0] a, sd, raw, pc;
      logic [4:0] dst;
      logic [1:0] sz;
      logic wen, u, ld, st, wr;
      int kind, n, waits;
      kind = $urandom_range(0, 3);
      sz = 2'($urandom_range(0, 3));
      if (kind == 3 && sz == 0) sz = 1;
      n = 1 << sz;
      a = {$urandom, $urandom};
      if (kind == 3) a = (a & ~64'h7) | 64'($urandom_range(1, n - 1));
      else if (kind != 0) a = a & ~64'(n - 1);
      sd = {$urandom, $urandom}; raw = {$urandom, $urandom}; pc = {$urandom, $urandom};
      dst = 5'($urandom); wen = 1'($urandom); u = 1'($urandom);
      ld = 0; st = 0;
      if (kind == 1) begin ld = 1; st = 1'($urandom); end
      else if (kind == 2) st = 1;
      else if (kind == 3) begin ld = 1'($urandom); st = !ld; end
      wr = st && !ld;
      in_valid = 1; in_load = ld; in_store = st; in_size = sz; in_unsigned = u; in_result = a;
      in_store_data = sd; in_pc = pc; in_dst = dst; in_wen = wen;
      dresp_ok = 1'($urandom); dresp_data = {$urandom, $urandom};
      vec++; if (in_ready !== 1'b1) begin err++; $display("FAIL rnd_ready[%0d] got %b exp 1", i, in_ready); end
      tick();
      in_valid = 0; dresp_ok = 0;
      if (kind == 0 || kind == 3) begin
        vec++; if (out_valid !== 1'b1 || out_misalign !== (kind == 3) || out_data !== (kind == 0 ? a : 64'h0) ||
                   out_wen !== (kind == 0 ? wen : 1'b0) || out_pc !== pc || out_dst !== dst || dreq_valid !== 1'b0)
          begin err++; $display("FAIL rnd_pass[%0d] got v%b m%b d%h w%b dv%b exp v1 m%b d%h", i, out_valid, out_misalign, out_data, out_wen, dreq_valid, kind == 3, kind == 0 ? a : 64'h0); end
      end else begin
        vec++; if (out_valid !== 1'b0 || dreq_valid !== 1'b1 || dreq_write !== wr || dreq_addr !== a || dreq_size !== sz ||
                   dreq_strobe !== (wr ? model_strobe(a, sz) : 8'h0) || dreq_wdata !== (wr ? sd << (8 * int'(a[2:0])) : 64'h0))
          begin err++; $display("FAIL rnd_req[%0d] got dv%b w%b a%h s%h wd%h exp w%b a%h s%h", i, dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata, wr, a, wr ? model_strobe(a, sz) : 8'h0); end
        waits = $urandom_range(0, 3);
        for (int w = 0; w < waits; w++) begin
          tick();
          vec++; if (dreq_valid !== 1'b1 || dreq_addr !== a || in_ready !== 1'b0 || out_valid !== 1'b0)
            begin err++; $display("FAIL rnd_wait[%0d] got dv%b a%h r%b v%b exp 1 %h 0 0", i, dreq_valid, dreq_addr, in_ready, out_valid, a); end
        end
        dresp_ok = 1; dresp_data = raw;
        tick();
        dresp_ok = 0;
        vec++; if (out_valid !== 1'b1 || out_misalign !== 1'b0 || out_data !== (wr ? 64'h0 : model_load(raw, a, sz, u)) ||
                   out_wen !== (wr ? 1'b0 : wen) || out_pc !== pc || out_dst !== dst || in_ready !== 1'b1)
          begin err++; $display("FAIL rnd_resp[%0d] got v%b d%h w%b r%b exp v1 d%h w%b", i, out_valid, out_data, out_wen, in_ready, wr ? 64'h0 : model_load(raw, a, sz, u), wr ? 1'b0 : wen); end
      end
    end
    in_load = 0; in_store = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_byte();
    test_store_word();
    test_misalign();
    test_reset_busy();
    test_ld_then_addi();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
